mezz_config_scheduler: RTL

//  Sequences configuration of up to NUM_MEZZ mezzanine cards through the single shared JTAG config path (mezzanine config block + JTAG master).
//  Per enabled card: selects its chain, waits for the chain mux to settle, then issues ASD and/or TDC config requests.

---
 rtl/mezz_config_scheduler.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mezz_config_scheduler.sv
// rtl/mezz_config_scheduler.sv - sequences per-card JTAG configuration with retry and pass/fail bitmaps
//
// Walks the enabled mezzanine cards one at a time through the shared JTAG
// config path: select chain, let the mux settle, issue ASD and/or TDC config
// requests, judge chain_success, retry a bounded number of times, and record
// a per-card verdict.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               1-cycle start pulse (IDLE only)
//   i_abort               level; returns to IDLE without a done pulse
//   i_mezz_mask           card enables, latched at start
//   i_do_asd, i_do_tdc    step enables, latched at start
//   i_asd_config_done     1-cycle done pulse for the ASD step
//   i_tdc_config_done     1-cycle done pulse for the TDC step
//   i_chain_success       [5:1] TDC chains, [0] ASD; valid with its done pulse
//   o_mezz_sel            index of the selected card
//   o_asd_config          1-cycle ASD request
//   o_tdc_config          1-cycle TDC request
//   o_busy                high whenever not IDLE
//   o_done                1-cycle pulse on normal completion
//   o_mezz_pass           per-card pass bitmap
//   o_mezz_fail           per-card fail bitmap
//   o_timeout_seen        sticky, any wait timed out since start

module mezz_config_scheduler #(
    parameter int NUM_MEZZ    = 18,
    parameter int IDX_W       = 5,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2**20,
    parameter int TO_W        = 21,
    parameter int MAX_RETRY   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [NUM_MEZZ-1:0] i_mezz_mask,
    input  logic                i_do_asd,
    input  logic                i_do_tdc,
    input  logic                i_asd_config_done,
    input  logic                i_tdc_config_done,
    input  logic [5:0]          i_chain_success,
    output logic [IDX_W-1:0]    o_mezz_sel,
    output logic                o_asd_config,
    output logic                o_tdc_config,
    output logic                o_busy,
    output logic                o_done,
    output logic [NUM_MEZZ-1:0] o_mezz_pass,
    output logic [NUM_MEZZ-1:0] o_mezz_fail,
    output logic                o_timeout_seen
);

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Index is one bit wider than mezz_sel so it can reach NUM_MEZZ (end of scan).
    localparam logic [IDX_W:0]    IDX_END     = (IDX_W + 1)'(NUM_MEZZ);
    localparam logic [IDX_W:0]    IDX_ONE     = (IDX_W + 1)'(1);
    localparam logic [ST_W-1:0]   SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [TO_W-1:0]   TIMER_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0]   RETRY_MAX   = RT_W'(MAX_RETRY);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SELECT   = 4'd1;
    localparam logic [3:0] S_SETTLE   = 4'd2;
    localparam logic [3:0] S_ASD_REQ  = 4'd3;
    localparam logic [3:0] S_ASD_WAIT = 4'd4;
    localparam logic [3:0] S_TDC_REQ  = 4'd5;
    localparam logic [3:0] S_TDC_WAIT = 4'd6;
    localparam logic [3:0] S_CHECK    = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    logic [3:0]          r_state;
    logic [IDX_W:0]      r_idx;
    logic [NUM_MEZZ-1:0] r_mask;
    logic                r_do_asd;
    logic                r_do_tdc;
    logic [ST_W-1:0]     r_settle_cnt;
    logic [TO_W-1:0]     r_timer;
    logic [RT_W-1:0]     r_retry;
    logic                r_ok;
    logic [IDX_W-1:0]    r_mezz_sel;
    logic [NUM_MEZZ-1:0] r_pass;
    logic [NUM_MEZZ-1:0] r_fail;
    logic                r_timeout_seen;
    logic                r_done;

    logic [NUM_MEZZ-1:0] w_idx_onehot;
    logic                w_mask_hit;
    logic                w_asd_ok;
    logic                w_tdc_ok;
    logic                w_timer_expired;

    // One-hot of the current index; all-zero once idx reaches NUM_MEZZ.
    assign w_idx_onehot    = NUM_MEZZ'(1) << r_idx;
    assign w_mask_hit      = |(r_mask & w_idx_onehot);
    assign w_asd_ok        = r_ok & i_chain_success[0];
    assign w_tdc_ok        = r_ok & (&i_chain_success[5:1]);
    assign w_timer_expired = (r_timer == TIMER_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_mask         <= '0;
            r_do_asd       <= 1'b0;
            r_do_tdc       <= 1'b0;
            r_settle_cnt   <= '0;
            r_timer        <= '0;
            r_retry        <= '0;
            r_ok           <= 1'b0;
            r_mezz_sel     <= '0;
            r_pass         <= '0;
            r_fail         <= '0;
            r_timeout_seen <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                // Bitmaps and mezz_sel keep their partial values for post-mortem.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_mask         <= i_mezz_mask;
                            r_do_asd       <= i_do_asd;
                            r_do_tdc       <= i_do_tdc;
                            r_idx          <= '0;
                            r_pass         <= '0;
                            r_fail         <= '0;
                            r_timeout_seen <= 1'b0;
                            r_state        <= S_SELECT;
                        end
                    end

                    S_SELECT: begin
                        if (r_idx == IDX_END) begin
                            r_state <= S_FINISH;
                        end else if (!w_mask_hit) begin
                            r_idx <= r_idx + IDX_ONE;
                        end else begin
                            r_mezz_sel   <= r_idx[IDX_W-1:0];
                            r_retry      <= '0;
                            r_ok         <= 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end
                    end

                    S_SETTLE: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            if (r_do_asd) begin
                                r_state <= S_ASD_REQ;
                            end else if (r_do_tdc) begin
                                r_state <= S_TDC_REQ;
                            end else begin
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end

                    S_ASD_REQ: begin
                        r_timer <= '0;
                        r_state <= S_ASD_WAIT;
                    end

                    S_ASD_WAIT: begin
                        // A done pulse beats a coincident timeout.
                        if (i_asd_config_done) begin
                            r_ok <= w_asd_ok;
                            // A card whose ASD step failed is not worth a TDC pass;
                            // go straight to the verdict and retry from SETTLE.
                            if (w_asd_ok && r_do_tdc) begin
                                r_state <= S_TDC_REQ;
                            end else begin
                                r_state <= S_CHECK;
                            end
                        end else if (w_timer_expired) begin
                            r_ok           <= 1'b0;
                            r_timeout_seen <= 1'b1;
                            r_state        <= S_CHECK;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end

                    S_TDC_REQ: begin
                        r_timer <= '0;
                        r_state <= S_TDC_WAIT;
                    end

                    S_TDC_WAIT: begin
                        if (i_tdc_config_done) begin
                            r_ok    <= w_tdc_ok;
                            r_state <= S_CHECK;
                        end else if (w_timer_expired) begin
                            r_ok           <= 1'b0;
                            r_timeout_seen <= 1'b1;
                            r_state        <= S_CHECK;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end

                    S_CHECK: begin
                        if (r_ok) begin
                            r_pass  <= r_pass | w_idx_onehot;
                            r_idx   <= r_idx + IDX_ONE;
                            r_state <= S_SELECT;
                        end else if (r_retry < RETRY_MAX) begin
                            r_retry      <= r_retry + 1'b1;
                            r_ok         <= 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_fail  <= r_fail | w_idx_onehot;
                            r_idx   <= r_idx + IDX_ONE;
                            r_state <= S_SELECT;
                        end
                    end

                    S_FINISH: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Requests are decoded from state so they last exactly one cycle; abort
    // masks them combinationally so nothing escapes in the abort cycle.
    assign o_asd_config   = (r_state == S_ASD_REQ) && !i_abort;
    assign o_tdc_config   = (r_state == S_TDC_REQ) && !i_abort;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_mezz_sel     = r_mezz_sel;
    assign o_mezz_pass    = r_pass;
    assign o_mezz_fail    = r_fail;
    assign o_timeout_seen = r_timeout_seen;

endmodule
